gf180mcu_osu_sc_12t_cell_bist_seq: RTL and testbench

//  Exhaustive built-in self-test sequencer for one combinational single-output library cell
//  (and2, nand2, aoi21, oai21, xnor2, ...). It steps the cell inputs through every vector
//  0..2**NIN-1 and waits a programmable settle time on each vector. It then compares the

---
 rtl/gf180mcu_osu_sc_12t_cell_bist_seq_if.sv | 28 ++
 rtl/gf180mcu_osu_sc_12t_cell_bist_seq.sv | 127 ++++++++++++
 tb/tb_gf180mcu_osu_sc_12t_cell_bist_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gf180mcu_osu_sc_12t_cell_bist_seq_if.sv
// Signal bundle between the cell BIST sequencer and its harness.
// The master drives the run request, the truth table and the cell output.
interface gf180mcu_osu_sc_12t_cell_bist_seq_if #(
   parameter int unsigned NIN = 3,
   parameter int unsigned SW  = 4
) ();
   logic                   START;
   logic [(1 << NIN)-1:0]  EXP;
   logic [SW-1:0]          SETTLE_CYC;
   logic                   STOP_ON_FAIL;
   logic                   Y_DUT;
   logic [NIN-1:0]         VEC;
   logic                   BUSY;
   logic                   DONE;
   logic                   PASS;
   logic [NIN-1:0]         FAIL_VEC;
   logic [NIN:0]           ERR_CNT;

   modport master (
      output START, EXP, SETTLE_CYC, STOP_ON_FAIL, Y_DUT,
      input  VEC, BUSY, DONE, PASS, FAIL_VEC, ERR_CNT
   );

   modport slave (
      input  START, EXP, SETTLE_CYC, STOP_ON_FAIL, Y_DUT,
      output VEC, BUSY, DONE, PASS, FAIL_VEC, ERR_CNT
   );
endinterface

// File: rtl/gf180mcu_osu_sc_12t_cell_bist_seq.sv
// Exhaustive self-test sequencer for a single-output combinational cell: walks every input
// vector, waits a settle time, compares against a latched truth table and reports results.
module gf180mcu_osu_sc_12t_cell_bist_seq #(
   parameter int unsigned NIN = 3,
   parameter int unsigned SW  = 4
) (
   input logic                                 CLK,
   input logic                                 R,
   gf180mcu_osu_sc_12t_cell_bist_seq_if.slave  bus
);
   localparam int unsigned N = 1 << NIN;

   typedef enum logic [1:0] {StIdle, StApply, StCheck, StFinish} state_e;

   state_e         state_q, state_d;
   logic [N-1:0]   exp_q, exp_d;
   logic [SW-1:0]  settle_q, settle_d;
   logic [SW-1:0]  cnt_q, cnt_d;
   logic           stop_q, stop_d;
   logic [NIN-1:0] vec_q, vec_d;
   logic [NIN-1:0] fail_vec_q, fail_vec_d;
   logic [NIN:0]   err_cnt_q, err_cnt_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           pass_q, pass_d;
   logic           mis;
   logic [NIN:0]   err_inc;

   always_comb begin
      state_d    = state_q;
      exp_d      = exp_q;
      settle_d   = settle_q;
      cnt_d      = cnt_q;
      stop_d     = stop_q;
      vec_d      = vec_q;
      fail_vec_d = fail_vec_q;
      err_cnt_d  = err_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pass_d     = pass_q;
      mis        = 1'b0;
      err_inc    = err_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (bus.START) begin
               exp_d      = bus.EXP;
               // A zero settle field still holds each vector for one cycle.
               settle_d   = (bus.SETTLE_CYC == '0) ? SW'(1) : bus.SETTLE_CYC;
               stop_d     = bus.STOP_ON_FAIL;
               cnt_d      = settle_d - SW'(1);
               vec_d      = '0;
               err_cnt_d  = '0;
               fail_vec_d = '0;
               pass_d     = 1'b0;
               busy_d     = 1'b1;
               state_d    = StApply;
            end
         end
         StApply: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - SW'(1);
            end else begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            mis       = bus.Y_DUT ^ exp_q[vec_q];
            err_inc   = err_cnt_q + {{NIN{1'b0}}, mis};
            err_cnt_d = err_inc;
            if (mis && (err_cnt_q == '0)) begin
               fail_vec_d = vec_q;
            end
            if ((mis && stop_q) || (&vec_q)) begin
               pass_d  = (err_inc == '0);
               done_d  = 1'b1;
               state_d = StFinish;
            end else begin
               vec_d   = vec_q + {{(NIN-1){1'b0}}, 1'b1};
               cnt_d   = settle_q - SW'(1);
               state_d = StApply;
            end
         end
         StFinish: begin
            vec_d   = '0;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (R) begin
         state_q    <= StIdle;
         exp_q      <= '0;
         settle_q   <= '0;
         cnt_q      <= '0;
         stop_q     <= 1'b0;
         vec_q      <= '0;
         fail_vec_q <= '0;
         err_cnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         settle_q   <= settle_d;
         cnt_q      <= cnt_d;
         stop_q     <= stop_d;
         vec_q      <= vec_d;
         fail_vec_q <= fail_vec_d;
         err_cnt_q  <= err_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
      end
   end

   assign bus.VEC      = vec_q;
   assign bus.BUSY     = busy_q;
   assign bus.DONE     = done_q;
   assign bus.PASS     = pass_q;
   assign bus.FAIL_VEC = fail_vec_q;
   assign bus.ERR_CNT  = err_cnt_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_cell_bist_seq.sv
// Directed bench for the cell BIST sequencer: a 2-input and a 3-input instance, each
// fed by a behavioural cell model selected per step.
module tb_gf180mcu_osu_sc_12t_cell_bist_seq;
   logic CLK = 1'b0;
   logic R   = 1'b1;
   int   n_total = 0;
   int   n_pass  = 0;
   int   ymode2  = 0;
   int   done_cnt2 = 0;
   int   done_cnt3 = 0;
   int   cyc;
   int   d_before;
   int   first_done;

   always #5 CLK = ~CLK;

   gf180mcu_osu_sc_12t_cell_bist_seq_if #(.NIN(2), .SW(4)) if2 ();
   gf180mcu_osu_sc_12t_cell_bist_seq_if #(.NIN(3), .SW(4)) if3 ();

   gf180mcu_osu_sc_12t_cell_bist_seq #(.NIN(2), .SW(4)) dut2 (.CLK(CLK), .R(R), .bus(if2));
   gf180mcu_osu_sc_12t_cell_bist_seq #(.NIN(3), .SW(4)) dut3 (.CLK(CLK), .R(R), .bus(if3));

   // 0: and2, 1: stuck-at-0, 2: xor2, 3: nand2
   assign if2.Y_DUT = (ymode2 == 0) ? (&if2.VEC) :
                      (ymode2 == 1) ? 1'b0 :
                      (ymode2 == 2) ? (^if2.VEC) : ~(&if2.VEC);
   // aoi21 with the single OR input on VEC[0]; this is the function EXP=8'h15 encodes.
   assign if3.Y_DUT = ~(if3.VEC[0] | (if3.VEC[1] & if3.VEC[2]));

   always @(negedge CLK) begin
      if (if2.DONE === 1'b1) done_cnt2++;
      if (if3.DONE === 1'b1) done_cnt3++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic accept2();
      if2.START = 1'b1;
      @(posedge CLK); #1;
      if2.START = 1'b0;
   endtask

   task automatic accept3();
      if3.START = 1'b1;
      @(posedge CLK); #1;
      if3.START = 1'b0;
   endtask

   // Returns the cycle (1 = first APPLY) in which DONE is seen; 200 on timeout.
   task automatic wait_done2(output int c);
      c = 1;
      while (if2.DONE !== 1'b1 && c < 200) begin
         @(posedge CLK); #1;
         c++;
      end
   endtask

   task automatic wait_done3(output int c);
      c = 1;
      while (if3.DONE !== 1'b1 && c < 200) begin
         @(posedge CLK); #1;
         c++;
      end
   endtask

   initial begin
      if2.START = 1'b0; if2.EXP = '0; if2.SETTLE_CYC = '0; if2.STOP_ON_FAIL = 1'b0;
      if3.START = 1'b0; if3.EXP = '0; if3.SETTLE_CYC = '0; if3.STOP_ON_FAIL = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_vec", 32'(if2.VEC), 0);
      check("rst_busy", 32'(if2.BUSY), 0);
      check("rst_done", 32'(if2.DONE), 0);
      check("rst_pass", 32'(if2.PASS), 0);
      check("rst_failvec", 32'(if2.FAIL_VEC), 0);
      check("rst_errcnt", 32'(if2.ERR_CNT), 0);
      R = 1'b0;
      @(posedge CLK); #1;

      // 1: and2 correct; inputs scrambled after accept must not matter
      ymode2 = 0; if2.EXP = 4'b1000; if2.SETTLE_CYC = 4'd2; if2.STOP_ON_FAIL = 1'b0;
      accept2();
      if2.EXP = 4'b0000; if2.SETTLE_CYC = 4'd9; if2.STOP_ON_FAIL = 1'b1;
      check("s1_busy_c1", 32'(if2.BUSY), 1);
      wait_done2(cyc);
      check("s1_done_cyc", 32'(cyc), 13);
      check("s1_pass", 32'(if2.PASS), 1);
      check("s1_errcnt", 32'(if2.ERR_CNT), 0);
      check("s1_failvec", 32'(if2.FAIL_VEC), 0);
      check("s1_busy_fin", 32'(if2.BUSY), 1);
      @(posedge CLK); #1;
      check("s1_busy_idle", 32'(if2.BUSY), 0);
      check("s1_done_low", 32'(if2.DONE), 0);
      check("s1_pass_hold", 32'(if2.PASS), 1);

      // 2: and2 stuck-at-0
      ymode2 = 1; if2.EXP = 4'b1000; if2.SETTLE_CYC = 4'd2; if2.STOP_ON_FAIL = 1'b0;
      accept2();
      check("s2_pass_clr", 32'(if2.PASS), 0);
      wait_done2(cyc);
      check("s2_done_cyc", 32'(cyc), 13);
      check("s2_pass", 32'(if2.PASS), 0);
      check("s2_errcnt", 32'(if2.ERR_CNT), 1);
      check("s2_failvec", 32'(if2.FAIL_VEC), 3);
      @(posedge CLK); #1;
      check("s2_failvec_hold", 32'(if2.FAIL_VEC), 3);

      // every vector wrong: count reaches N, first failure kept
      ymode2 = 3;
      accept2();
      wait_done2(cyc);
      check("all_done_cyc", 32'(cyc), 13);
      check("all_errcnt", 32'(if2.ERR_CNT), 4);
      check("all_failvec", 32'(if2.FAIL_VEC), 0);
      @(posedge CLK); #1;

      // 3: xnor2 expected, xor2 cell, stop on first failure
      ymode2 = 2; if2.EXP = 4'b1001; if2.SETTLE_CYC = 4'd1; if2.STOP_ON_FAIL = 1'b1;
      accept2();
      wait_done2(cyc);
      check("s3_done_cyc", 32'(cyc), 3);
      check("s3_failvec", 32'(if2.FAIL_VEC), 0);
      check("s3_errcnt", 32'(if2.ERR_CNT), 1);
      check("s3_pass", 32'(if2.PASS), 0);
      @(posedge CLK); #1;
      check("s3_vec_after", 32'(if2.VEC), 0);
      check("s3_busy_after", 32'(if2.BUSY), 0);

      // 4: 3-input cell, settle 0 treated as 1
      if3.EXP = 8'h15; if3.SETTLE_CYC = 4'd0; if3.STOP_ON_FAIL = 1'b0;
      accept3();
      wait_done3(cyc);
      check("s4_done_cyc", 32'(cyc), 17);
      check("s4_pass", 32'(if3.PASS), 1);
      check("s4_errcnt", 32'(if3.ERR_CNT), 0);
      @(posedge CLK); #1;

      // 5: START pulses in cycles 4 and 17 are ignored
      d_before = done_cnt3;
      first_done = 0;
      accept3();
      for (int c = 1; c <= 24; c++) begin
         if3.START = (c == 4) || (c == 17);
         if (if3.DONE === 1'b1 && first_done == 0) first_done = c;
         @(posedge CLK); #1;
      end
      if3.START = 1'b0;
      check("s5_done_cyc", 32'(first_done), 17);
      check("s5_done_count", 32'(done_cnt3 - d_before), 1);
      check("s5_busy_idle", 32'(if3.BUSY), 0);
      check("s5_pass", 32'(if3.PASS), 1);
      check("s5_errcnt", 32'(if3.ERR_CNT), 0);

      // 6: reset in cycle 6 aborts, then a clean rerun
      ymode2 = 0; if2.EXP = 4'b1000; if2.SETTLE_CYC = 4'd2; if2.STOP_ON_FAIL = 1'b0;
      d_before = done_cnt2;
      accept2();
      repeat (5) begin
         @(posedge CLK); #1;
      end
      check("s6_vec_c6", 32'(if2.VEC), 1);
      R = 1'b1;
      @(posedge CLK); #1;
      R = 1'b0;
      check("s6_rst_vec", 32'(if2.VEC), 0);
      check("s6_rst_busy", 32'(if2.BUSY), 0);
      check("s6_rst_done", 32'(if2.DONE), 0);
      check("s6_rst_pass", 32'(if2.PASS), 0);
      @(posedge CLK); #1;
      check("s6_no_done", 32'(done_cnt2 - d_before), 0);
      accept2();
      wait_done2(cyc);
      check("s6_done_cyc", 32'(cyc), 13);
      check("s6_pass", 32'(if2.PASS), 1);
      @(posedge CLK); #1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
